// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shift one command byte with odd
// parity on device clock falls, then report ack (done), nack or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES     = 5000,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
  parameter int unsigned XFER_TIMEOUT       = 100000,
  parameter int unsigned FILTER_LEN         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       nack_err,
  output logic       timeout_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [19:0]   INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]   FE_LAST   = 20'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [19:0]   XF_LAST   = 20'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, fall_q;
  logic [FW-1:0] fcnt_q, fcnt_d;

  state_t        state_q;
  logic          busy_q, clk_oe_q, dat_oe_q, done_q, nack_q, to_q;
  logic [19:0]   timer_q;
  logic [3:0]    idx_q, idx_n;
  logic [7:0]    data_q;
  logic          par_q, nxt_bit;

  // Idle PS/2 lines float high, so the synchronizers and filter start at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      fall_q   <= filt_q & ~filt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) filt_d = clk_s2_q;
      else                     fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Frame after the start bit: data[0..7], parity, stop (1).
  assign idx_n = idx_q + 4'd1;
  always_comb begin
    nxt_bit = 1'b1;
    if (idx_n < 4'd8)       nxt_bit = data_q[idx_n[2:0]];
    else if (idx_n == 4'd8) nxt_bit = par_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      to_q     <= 1'b0;
      timer_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
      timer_q <= timer_q + 20'd1;
      unique case (state_q)
        S_IDLE: begin
          // busy lingers one cycle after a result pulse, which blocks acceptance here.
          busy_q   <= 1'b0;
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (tx_valid && !busy_q) begin
            data_q   <= tx_data;
            par_q    <= ~^tx_data;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (timer_q == INH_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (fall_q) begin
            dat_oe_q <= ~data_q[0];
            idx_q    <= '0;
            timer_q  <= '0;
            state_q  <= S_SHIFT;
          end else if (timer_q == FE_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            to_q     <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (fall_q) begin
            idx_q    <= idx_n;
            dat_oe_q <= ~nxt_bit;
            if (idx_q == 4'd8) state_q <= S_ACK;
          end else if (timer_q == XF_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            to_q     <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_ACK: begin
          if (fall_q) begin
            if (dat_s2_q) begin
              nack_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT_IDLE;
            end
          end else if (timer_q == XF_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            to_q     <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s2_q && dat_s2_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (timer_q == XF_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            to_q     <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = dat_oe_q;
  assign done        = done_q;
  assign nack_err    = nack_q;
  assign timeout_err = to_q;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send half of the keyboard link, complementing the existing PS/2 receive path. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard using the host-request-to-send sequence, then reports success, NACK or timeout. It sits beside the PS/2 receiver at top level. Top level turns the two open-drain enables into the `ps2_clock`/`ps2_data` inouts, driving 0 when enabled and `z` otherwise.

## Interface
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low to request send (100 µs at 50 MHz).
- `FIRST_EDGE_TIMEOUT`, 750000: max cycles from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT`, 100000: max cycles from first falling edge to ack sampled (2 ms).
- `FILTER_LEN`, 8: consecutive equal samples needed to change the filtered PS/2 clock level.
- All counts must be < 2^20. The timer is 20 bits.
- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_data` in 8: command byte, sampled on acceptance.
- `busy` out 1: high from the cycle after acceptance until return to IDLE.
- `ps2_clk_in` in 1: raw PS/2 clock line level (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data line level (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the clock line low.
- `ps2_data_oe` out 1: 1 pulls the data line low.
- `done` out 1: one-cycle pulse when the device acked (data low at the ack edge).
- `nack_err` out 1: one-cycle pulse when data was high at the ack edge.
- `timeout_err` out 1: one-cycle pulse when either timeout expires.

## Operation
- **Input conditioning**
  - Both PS/2 inputs pass through a 2-flop synchronizer.
  - The clock is then filtered: the filtered level becomes 1 or 0 only after `FILTER_LEN` consecutive equal samples; otherwise it holds.
  - `fall` is a one-cycle strobe when the filtered clock goes 1→0.
- **Acceptance:** the byte is accepted when `tx_valid && !busy`. The byte is latched and odd parity computed, so parity = ~^data. `tx_valid` while busy is ignored, not queued.
- **States**
  - IDLE: both oe = 0. On acceptance → INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles → REQ.
  - REQ: `ps2_data_oe`=1 (start bit 0) and `ps2_clk_oe`=0, asserted in the same cycle. Timer restarts. On `fall` → SHIFT with bit index 0. Timer reaching `FIRST_EDGE_TIMEOUT` → error.
  - SHIFT: frame order is data bits 0–7 LSB first, then parity, then stop.
    - On the first `fall`, drive bit0. Each later `fall` drives the next bit.
    - Drive rule: `ps2_data_oe` = ~bit.
    - The stop bit is 1, so `ps2_data_oe`=0.
    - Timer restarts on entry. After the stop bit is driven → ACK.
  - ACK: on the next `fall`, sample synchronized data. 0 → WAIT_IDLE. 1 → pulse `nack_err`, → IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1 → pulse `done`, → IDLE.
  - `XFER_TIMEOUT` applies from SHIFT entry through WAIT_IDLE. Expiry → error.
- **Error handling:** both oe go to 0 in the same cycle, `timeout_err` pulses, → IDLE.
- At most one of `done`/`nack_err`/`timeout_err` pulses per command.

## Timing
- **Reset values:** `busy`=0, both oe=0, all pulses 0, state IDLE. Reset mid-transfer releases both lines immediately (asynchronously).
- **Acceptance at cycle N:**
  - `busy`=1 and `ps2_clk_oe`=1 at N+1.
  - `ps2_clk_oe` falls and `ps2_data_oe` rises at N+1+`INHIBIT_CYCLES`.
- **Edge latency:** a raw clock fall is seen as `fall` 2+`FILTER_LEN` cycles later. The oe update is one cycle after `fall`.
- **Completion:** `busy` drops in the cycle after the `done`/`nack_err`/`timeout_err` pulse. A new `tx_valid` is accepted from that cycle.
- **Frame length:** exactly 11 device falling edges per successful frame:
  - edge 1: bit0
  - edges 2–8: bits 1–7
  - edge 9: parity
  - edge 10: stop
  - edge 11: ack
- A device that keeps clocking after the ack is ignored, because the block is in WAIT_IDLE or IDLE.

## Test plan
- **Send 0xED:** bench device model clocks at ~12 kHz-equivalent with `INHIBIT_CYCLES`=50, `FILTER_LEN`=4, and acks. Required:
  - `ps2_clk_oe` high for exactly 50 cycles.
  - Data bits driven on edges 1–8: 1,0,1,1,0,1,1,1.
  - Parity 1, stop released.
  - `done` pulses once, `busy` falls.
- **Send 0xF4:** parity bit 0 driven on edge 9 (`ps2_data_oe`=1); `done` pulses.
- **NACK:** device holds data high at edge 11 → `nack_err` pulses once, no `done`, both oe=0.
- **First-edge timeout:** device never clocks, with `FIRST_EDGE_TIMEOUT`=200 → `timeout_err` exactly 200 cycles after REQ entry, lines released.
- **Mid-frame timeout and reset:**
  - Device stops after edge 5 → `timeout_err` after `XFER_TIMEOUT`.
  - Separate run: assert `reset` during INHIBIT → `ps2_clk_oe`=0 in the same cycle, `busy`=0.
- **Back-to-back and glitch rejection:**
  - `tx_valid` held high while busy with a different byte → only the first byte is sent.
  - A 2-cycle glitch on `ps2_clk_in` produces no `fall`.
